seq_divider: RTL and testbench

- Multi-cycle restoring divider, the inverse arithmetic companion to the ripple-carry adder datapath.
- Computes Quotient and Remainder of Dividend / Divisor, one quotient bit per clock.
- Uses one WIDTH+1-bit subtract/compare stage, a shift register and a small FSM.
- Drops into any datapath needing division without a combinational array divider; controlled by a Start/Busy/Done handshake.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/Busy/Done handshake and operand/result bus for seq_divider.
// The master side issues requests and the slave side is the divider.
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             Start;
   logic [WIDTH-1:0] Dividend;
   logic [WIDTH-1:0] Divisor;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic             Busy;
   logic             Done;
   logic             DivByZero;

   modport master (
      output Start, Dividend, Divisor,
      input  Quotient, Remainder, Busy, Done, DivByZero
   );

   modport slave (
      input  Start, Dividend, Divisor,
      output Quotient, Remainder, Busy, Done, DivByZero
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, Start/Busy/Done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds a one-cycle FIXUP sign stage).
module seq_divider #(
   parameter int WIDTH = 4
) (
   input logic         clk,
   input logic         rst,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
`ifdef SIGNED_DIV_EN
      , ST_FIXUP
`endif
   } state_e;

   state_e           state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] r_q, q_q, d_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic             busy_q, done_q, dbz_q, zero_q;
`ifdef SIGNED_DIV_EN
   logic             q_neg_q, r_neg_q;
`endif

   logic [WIDTH-1:0] a_mag, d_mag, r_d, q_d;
   logic [WIDTH:0]   shifted, trial;
   logic             last;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      a_mag = bus.Dividend;
      d_mag = bus.Divisor;
`ifdef SIGNED_DIV_EN
      if (bus.Dividend[WIDTH-1]) a_mag = -bus.Dividend;
      if (bus.Divisor[WIDTH-1])  d_mag = -bus.Divisor;
`endif
      // R stays below 2^(WIDTH-1) until the final shift, so r_q's MSB is always 0 here.
      shifted = {r_q, q_q[WIDTH-1]};
      trial   = shifted - {1'b0, d_q};
      r_d     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
      last    = (count_q == CW'(WIDTH - 1));
   end

   // NOTE: sequential state uses non-blocking assignments only; all registers,
   // datapath included, are cleared by reset because results are observable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         zero_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.Start) begin
                  count_q <= '0;
                  r_q     <= '0;
                  d_q     <= d_mag;
                  dbz_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  zero_q  <= (bus.Divisor == '0);
                  // a zero divisor parks the raw dividend in q_q for the remainder
                  q_q     <= (bus.Divisor == '0) ? bus.Dividend : a_mag;
`ifdef SIGNED_DIV_EN
                  q_neg_q <= bus.Dividend[WIDTH-1] ^ bus.Divisor[WIDTH-1];
                  r_neg_q <= bus.Dividend[WIDTH-1];
`endif
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (zero_q) begin
                  quotient_q  <= '1;
                  remainder_q <= q_q;
                  dbz_q       <= 1'b1;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  r_q     <= r_d;
                  q_q     <= q_d;
                  count_q <= count_q + CW'(1);
                  if (last) begin
`ifdef SIGNED_DIV_EN
                     state_q     <= ST_FIXUP;
`else
                     quotient_q  <= q_d;
                     remainder_q <= r_d;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= ST_DONE;
`endif
                  end
               end
            end
`ifdef SIGNED_DIV_EN
            ST_FIXUP: begin
               quotient_q  <= q_neg_q ? -q_q : q_q;
               remainder_q <= r_neg_q ? -r_q : r_q;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               state_q     <= ST_DONE;
            end
`endif
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.Quotient  = quotient_q;
   assign bus.Remainder = remainder_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_seq_divider;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic cmp_en = 1'b0;

   seq_divider_if #(.WIDTH(W)) bus ();
   seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
   } res_t;

   // Expected result and busy length straight from the arithmetic definition.
   function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      res_t res;
`ifdef SIGNED_DIV_EN
      int sa, sb;
`endif
      if (b == '0) begin
         res.q = '1; res.r = a; res.z = 1'b1; res.lat = 1;
      end else begin
`ifdef SIGNED_DIV_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
         res.q = W'(sa / sb);
         res.r = W'(sa % sb);
         res.lat = W + 1;
`else
         res.q = a / b;
         res.r = a % b;
         res.lat = W;
`endif
         res.z = 1'b0;
      end
      return res;
   endfunction

   int           remain;
   logic         m_done, m_z;
   logic [W-1:0] m_q, m_r;
   res_t         pend;

   always @(posedge clk) begin
      if (rst) begin
         remain <= 0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_z <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (remain > 0) begin
         remain <= remain - 1;
         if (remain == 1) begin
            m_done <= 1'b1; m_q <= pend.q; m_r <= pend.r; m_z <= pend.z;
         end
      end else if (bus.Start) begin
         pend   <= ref_div(bus.Dividend, bus.Divisor);
         remain <= ref_div(bus.Dividend, bus.Divisor).lat;
         m_z    <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc Busy", 32'(bus.Busy), 32'(remain > 0));
         check("cyc Done", 32'(bus.Done), 32'(m_done));
         check("cyc Quotient", 32'(bus.Quotient), 32'(m_q));
         check("cyc Remainder", 32'(bus.Remainder), 32'(m_r));
         check("cyc DivByZero", 32'(bus.DivByZero), 32'(m_z));
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.Start = 1'b1; bus.Dividend = a; bus.Divisor = b;
      @(negedge clk);
      bus.Start = 1'b0; bus.Dividend = W'($urandom); bus.Divisor = W'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus.Done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int elat);
      int n;
      start_op(a, b);
      wait_done(n);
      check({tag, " latency"}, 32'(n), 32'(elat));
      check({tag, " Q"}, 32'(bus.Quotient), 32'(eq));
      check({tag, " R"}, 32'(bus.Remainder), 32'(er));
      check({tag, " DivByZero"}, 32'(bus.DivByZero), 32'(ez));
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int n, dones, lat;
      rst = 1'b1; bus.Start = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      check("reset Q", 32'(bus.Quotient), 32'd0);
      check("reset R", 32'(bus.Remainder), 32'd0);
      check("reset Busy", 32'(bus.Busy), 32'd0);
      check("reset Done", 32'(bus.Done), 32'd0);
      check("reset DivByZero", 32'(bus.DivByZero), 32'd0);

`ifdef SIGNED_DIV_EN
      run_div("-7/2", 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 5);
      run_div("7/-2", 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 5);
      run_div("-8/-1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 5);
      run_div("7/0", 4'd7, 4'd0, 4'b1111, 4'b0111, 1'b1, 1);
      run_div("6/2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 5);
`else
      run_div("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);
      run_div("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
      run_div("3/9", 4'd3, 4'd9, 4'd0, 4'd3, 1'b0, 4);
      repeat (3) @(negedge clk);
      check("hold Q", 32'(bus.Quotient), 32'd0);
      check("hold R", 32'(bus.Remainder), 32'd3);
      run_div("7/0", 4'd7, 4'd0, 4'b1111, 4'b0111, 1'b1, 1);
      run_div("6/2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 4);
`endif

      // Start pulses while RUN/DONE must be ignored
      start_op(4'd12, 4'd5);
      dones = 0; lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.Done === 1'b1) begin
            dones++;
            lat = c;
         end
         bus.Start = (c == 1 || c == 3 || c == 4);
         bus.Dividend = 4'd9; bus.Divisor = 4'd1;
      end
      bus.Start = 1'b0;
      check("ignore done count", 32'(dones), 32'd1);
`ifdef SIGNED_DIV_EN
      check("ignore latency", 32'(lat), 32'd5);
      check("ignore Q", 32'(bus.Quotient), 32'd0);
      check("ignore R", 32'(bus.Remainder), 32'b1100);
`else
      check("ignore latency", 32'(lat), 32'd4);
      check("ignore Q", 32'(bus.Quotient), 32'd2);
      check("ignore R", 32'(bus.Remainder), 32'd2);
`endif

      // Reset mid-RUN, with Start asserted alongside it
      start_op(4'd14, 4'd4);
      @(negedge clk);
      rst = 1'b1; bus.Start = 1'b1; bus.Dividend = 4'd9; bus.Divisor = 4'd1;
      @(negedge clk);
      check("abort Q", 32'(bus.Quotient), 32'd0);
      check("abort R", 32'(bus.Remainder), 32'd0);
      check("abort Busy", 32'(bus.Busy), 32'd0);
      check("abort Done", 32'(bus.Done), 32'd0);
      rst = 1'b0; bus.Start = 1'b0;
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.Done === 1'b1) dones++;
      end
      check("abort no Done", 32'(dones), 32'd0);
`ifdef SIGNED_DIV_EN
      run_div("14/4", 4'd14, 4'd4, 4'd0, 4'b1110, 1'b0, 5);
`else
      run_div("14/4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 4);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
